// File: rtl/bitstream_bit_reader.sv
// MSB-first bit window between the byte reader and the arithmetic decoder; 1-cycle read latency, stalls (rd_ready=0) until enough bits are buffered.
// Byte intake is held off while the window lacks room for a full byte; BITREADER_BYTE_ALIGN_EN adds an align_req port.
module bitstream_bit_reader #(
    parameter int BUF_W    = 32,
    parameter int MAX_READ = 16
) (
    input  logic                             clk,
    input  logic                             rst,
`ifdef BITREADER_BYTE_ALIGN_EN
    input  logic                             align_req,
`endif
    input  logic [7:0]                       byte_data,
    input  logic                             byte_ready,
    output logic                             byte_request,
    input  logic                             rd_req,
    input  logic [$clog2(MAX_READ+1)-1:0]    rd_num,
    output logic                             rd_ready,
    output logic [MAX_READ-1:0]              rd_data,
    output logic                             rd_valid,
    output logic [$clog2(BUF_W+1)-1:0]       fill_level
);
    localparam int NW = $clog2(MAX_READ + 1);
    localparam int FW = $clog2(BUF_W + 1);

    localparam logic       S_IDLE = 1'b0;
    localparam logic       S_WAIT = 1'b1;
    localparam logic [FW-1:0] ROOM_MAX = FW'(BUF_W - 8);
    localparam logic [NW-1:0] N_MAX    = NW'(MAX_READ);

    logic [BUF_W-1:0]    r_window;
    logic [FW-1:0]       r_fill;
    logic                r_state;
    logic [NW-1:0]       r_n;
    logic                r_rd_valid;
    logic [MAX_READ-1:0] r_rd_data;

    logic                w_take;
    logic [NW-1:0]       w_req_n;
    logic [NW-1:0]       w_cur_n;
    logic                w_enough;
    logic                w_consume;
    logic                w_align;
    logic [FW-1:0]       w_drop;
    logic [FW-1:0]       w_shift;
    logic [FW-1:0]       w_fill_after;
    logic [BUF_W-1:0]    w_win_shifted;
    logic [BUF_W-1:0]    w_byte_ext;
    logic [MAX_READ-1:0] w_top;
    logic [NW-1:0]       w_rsh;
    logic [MAX_READ-1:0] w_data;

    assign w_take  = byte_ready && (r_fill <= ROOM_MAX) && !rst;
    assign w_req_n = (rd_num > N_MAX) ? N_MAX : rd_num;
    assign w_cur_n = (r_state == S_IDLE) ? w_req_n : r_n;
    assign w_enough = (r_fill >= FW'(w_cur_n));
    assign w_consume = ((r_state == S_IDLE) && rd_req && w_enough) ||
                       ((r_state == S_WAIT) && w_enough);

`ifdef BITREADER_BYTE_ALIGN_EN
    // A read request in the same cycle wins over alignment.
    assign w_align = (r_state == S_IDLE) && !rd_req && align_req;
`else
    assign w_align = 1'b0;
`endif
    assign w_drop = w_align ? FW'(r_fill[2:0]) : '0;

    assign w_shift       = (w_consume ? FW'(w_cur_n) : '0) + w_drop;
    assign w_fill_after  = r_fill - w_shift;
    assign w_win_shifted = r_window << w_shift;
    // Bits below the valid region are always zero, so the byte can simply be OR-ed in.
    assign w_byte_ext    = {byte_data, {(BUF_W-8){1'b0}}} >> w_fill_after;

    assign w_top  = r_window[BUF_W-1 -: MAX_READ];
    assign w_rsh  = N_MAX - w_cur_n;
    assign w_data = w_top >> w_rsh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window   <= '0;
            r_fill     <= '0;
            r_state    <= S_IDLE;
            r_n        <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_window   <= w_win_shifted | (w_take ? w_byte_ext : '0);
            r_fill     <= w_fill_after + (w_take ? FW'(8) : FW'(0));
            r_rd_valid <= w_consume;
            if (w_consume) begin
                r_rd_data <= w_data;
            end
            if (r_state == S_IDLE) begin
                if (rd_req && !w_enough) begin
                    r_state <= S_WAIT;
                    r_n     <= w_req_n;
                end
            end else if (w_enough) begin
                r_state <= S_IDLE;
            end
        end
    end

    assign byte_request = w_take;
    assign rd_ready     = (r_state == S_IDLE);
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign fill_level   = r_fill;
endmodule

// File: tb/tb_bitstream_bit_reader.sv
// Directed scoreboard bench for bitstream_bit_reader: reads push expected data, a negedge monitor pops on rd_valid.
module tb_bitstream_bit_reader;
    localparam int BUF_W    = 32;
    localparam int MAX_READ = 16;
    localparam int NW = $clog2(MAX_READ + 1);
    localparam int FW = $clog2(BUF_W + 1);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [7:0]          byte_data = 8'h00;
    logic                byte_ready = 1'b0;
    logic                byte_request;
    logic                rd_req = 1'b0;
    logic [NW-1:0]       rd_num = '0;
    logic                rd_ready;
    logic [MAX_READ-1:0] rd_data;
    logic                rd_valid;
    logic [FW-1:0]       fill_level;
`ifdef BITREADER_BYTE_ALIGN_EN
    logic                align_req = 1'b0;
`endif

    always #5 clk = ~clk;

    bitstream_bit_reader #(.BUF_W(BUF_W), .MAX_READ(MAX_READ)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef BITREADER_BYTE_ALIGN_EN
        .align_req    (align_req),
`endif
        .byte_data    (byte_data),
        .byte_ready   (byte_ready),
        .byte_request (byte_request),
        .rd_req       (rd_req),
        .rd_num       (rd_num),
        .rd_ready     (rd_ready),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .fill_level   (fill_level)
    );

    int         exp_q[$];
    int         cyc_q[$];
    logic [7:0] src_q[$];
    int         n_vec   = 0;
    int         n_miss  = 0;
    int         n_valid = 0;
    int         cyc     = 0;
    logic       feed_take;

    task automatic check(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Upstream byte reader model: pops the front byte on every edge where byte_request was high.
    initial begin
        forever begin
            @(posedge clk);
            feed_take = byte_request;
            #1;
            if (feed_take && src_q.size() > 0) void'(src_q.pop_front());
            byte_ready = (src_q.size() > 0);
            byte_data  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        end
    end

    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            int e;
            int c;
            n_valid++;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL rd_valid_unexpected: got rd_data=%0h, required no pulse", rd_data);
            end else begin
                e = exp_q.pop_front();
                c = cyc_q.pop_front();
                check("rd_data", int'(rd_data), e);
                if (c >= 0) check("rd_latency_cycle", cyc, c);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic push_bytes(input logic [7:0] first, input int count);
        for (int i = 0; i < count; i++) src_q.push_back(first + 8'(i));
    endtask

    task automatic wait_fill(input int f, input string nm);
        int k = 0;
        while (int'(fill_level) != f && k < 40) begin
            tick(1);
            k++;
        end
        check(nm, int'(fill_level), f);
    endtask

    // Holds rd_req until the DUT accepts, then queues the expected result.
    task automatic do_read(input int n, input int exp, input bit lat);
        int k = 0;
        rd_req = 1'b1;
        rd_num = NW'(n);
        while (!rd_ready && k < 50) begin
            tick(1);
            k++;
        end
        if (!rd_ready) begin
            check("rd_accept_timeout", 0, 1);
            rd_req = 1'b0;
            return;
        end
        exp_q.push_back(exp);
        cyc_q.push_back(lat ? cyc + 1 : -1);
        tick(1);
        rd_req = 1'b0;
    endtask

    initial begin
        int nv;
        int k;
        // Reset state, with a byte already offered upstream.
        push_bytes(8'hA5, 1);
        push_bytes(8'h3C, 1);
        tick(2);
        check("reset_byte_request", int'(byte_request), 0);
        check("reset_fill", int'(fill_level), 0);
        check("reset_rd_ready", int'(rd_ready), 1);
        check("reset_rd_valid", int'(rd_valid), 0);
        check("reset_rd_data", int'(rd_data), 0);
        rst = 1'b0;

        // 0xA5,0x3C: 9 bits then 7 bits.
        wait_fill(16, "t1_fill16");
        do_read(9, 'h14A, 1'b1);
        do_read(7, 'h3C, 1'b1);
        check("t1_fill_end", int'(fill_level), 0);

        // Empty window stalls a read until a byte shows up.
        do_read(4, 'h9, 1'b0);
        check("t2_rd_ready_wait", int'(rd_ready), 0);
        nv = n_valid;
        tick(3);
        check("t2_no_valid", n_valid, nv);
        check("t2_still_wait", int'(rd_ready), 0);
        push_bytes(8'h9F, 1);
        k = 0;
        while (!rd_ready && k < 20) begin
            tick(1);
            k++;
        end
        check("t2_rd_ready_back", int'(rd_ready), 1);
        check("t2_fill4", int'(fill_level), 4);
        do_read(4, 'hF, 1'b1);

        // Saturate the window with no reads.
        push_bytes(8'h01, 8);
        tick(8);
        check("t3_fill_full", int'(fill_level), 32);
        check("t3_byte_request_low", int'(byte_request), 0);
        check("t3_bytes_left", src_q.size(), 4);
        do_read(8, 'h01, 1'b1);
        do_read(8, 'h02, 1'b1);
        do_read(8, 'h03, 1'b1);
        do_read(8, 'h04, 1'b1);

        // Zero-length read, then back-to-back 16-bit reads while bytes stream in.
        tick(4);
        check("t4_fill_full", int'(fill_level), 32);
        do_read(0, 0, 1'b1);
        check("t4_fill_unchanged", int'(fill_level), 32);
        push_bytes(8'h11, 8);
        do_read(16, 'h0506, 1'b0);
        do_read(16, 'h0708, 1'b0);
        do_read(16, 'h1112, 1'b0);
        do_read(16, 'h1314, 1'b0);
        do_read(16, 'h1516, 1'b0);
        do_read(16, 'h1718, 1'b0);
        tick(6);
        check("t4_fill_drained", int'(fill_level), 0);
        check("t4_rd_ready", int'(rd_ready), 1);

        // Reset while a 12-bit read waits on 8 buffered bits.
        push_bytes(8'h77, 1);
        wait_fill(8, "t5_fill8");
        rd_req = 1'b1;
        rd_num = NW'(12);
        tick(1);
        rd_req = 1'b0;
        check("t5_in_wait", int'(rd_ready), 0);
        check("t5_fill_wait", int'(fill_level), 8);
        nv = n_valid;
        rst = 1'b1;
        #1;
        check("t5_rst_rd_ready", int'(rd_ready), 1);
        check("t5_rst_fill", int'(fill_level), 0);
        tick(2);
        rst = 1'b0;
        tick(4);
        check("t5_no_valid_dropped", n_valid, nv);
        push_bytes(8'hC3, 1);
        wait_fill(8, "t5_fill_new");
        do_read(8, 'hC3, 1'b1);

`ifdef BITREADER_BYTE_ALIGN_EN
        push_bytes(8'hA5, 1);
        push_bytes(8'h3C, 1);
        wait_fill(16, "t6_fill16");
        do_read(3, 'h5, 1'b1);
        check("t6_fill13", int'(fill_level), 13);
        align_req = 1'b1;
        tick(1);
        align_req = 1'b0;
        check("t6_fill_aligned", int'(fill_level), 8);
        do_read(8, 'h3C, 1'b1);
        check("t6_fill_end", int'(fill_level), 0);
`endif

        tick(5);
        check("scoreboard_drain", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
